// File: rtl/operand_sequencer.sv
// Operand entry controller for the 16-bit operator cores: button conditioning,
// entry FSM (GET_A -> GET_B -> WAIT -> SHOW) and the result holding register.

module os_btn_cond #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);
  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;

  // Counter only runs while the synchronized level disagrees with the accepted
  // one; any bounce back to agreement restarts it.
  always_comb begin
    sync_d = {sync_q[0], btn};
    cnt_d  = '0;
    lvl_d  = lvl_q;
    pulse  = 1'b0;
    if (sync_q[1] != lvl_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        lvl_d = sync_q[1];
        pulse = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
    end
  end
endmodule

module operand_sequencer #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sw,
  input  logic        btn_enter,
  input  logic        btn_clear,
  input  logic [1:0]  op_sel,
  input  logic [15:0] fixA,
  input  logic [15:0] fixM,
  input  logic [15:0] floA,
  input  logic [15:0] floM,
  input  logic [3:0]  ovf_in,
  output logic [15:0] num1,
  output logic [15:0] num2,
  output logic [15:0] disp_value,
  output logic        disp_ovf,
  output logic [1:0]  state_led
);
  typedef enum logic [1:0] {GET_A = 2'b00, GET_B = 2'b01, WAIT_S = 2'b10, SHOW = 2'b11} state_e;

  logic [1:0] btn_raw, btn_pulse;
  assign btn_raw = {btn_clear, btn_enter};

  for (genvar i = 0; i < 2; i++) begin : g_btn
    os_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_btn (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_raw[i]),
      .pulse(btn_pulse[i])
    );
  end

  logic enter, clear;
  assign enter = btn_pulse[0];
  assign clear = btn_pulse[1];

  logic [15:0] res;
  logic        res_ovf;
  always_comb begin
    res     = fixA;
    res_ovf = ovf_in[0];
    case (op_sel)
      2'b00: begin res = fixA; res_ovf = ovf_in[0]; end
      2'b01: begin res = fixM; res_ovf = ovf_in[1]; end
      2'b10: begin res = floA; res_ovf = ovf_in[3]; end
      2'b11: begin res = floM; res_ovf = ovf_in[2]; end
      default: ;
    endcase
  end

  state_e      state_q, state_d;
  logic [15:0] num1_q, num1_d, num2_q, num2_d, disp_q, disp_d;
  logic        dovf_q, dovf_d;

  always_comb begin
    state_d = state_q;
    num1_d  = num1_q;
    num2_d  = num2_q;
    disp_d  = disp_q;
    dovf_d  = dovf_q;
    if (clear) begin
      state_d = GET_A;
      num1_d  = '0;
      num2_d  = '0;
      disp_d  = '0;
      dovf_d  = 1'b0;
    end else begin
      case (state_q)
        GET_A: begin
          disp_d = sw;
          dovf_d = 1'b0;
          if (enter) begin num1_d = sw; state_d = GET_B; end
        end
        GET_B: begin
          disp_d = sw;
          dovf_d = 1'b0;
          if (enter) begin num2_d = sw; state_d = WAIT_S; end
        end
        // One settle cycle for the combinational cores on the new num2.
        WAIT_S: state_d = SHOW;
        SHOW: begin
          disp_d = res;
          dovf_d = res_ovf;
          if (enter) begin num1_d = disp_q; state_d = GET_B; end
        end
        default: state_d = GET_A;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= GET_A;
      num1_q  <= '0;
      num2_q  <= '0;
      disp_q  <= '0;
      dovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num1_q  <= num1_d;
      num2_q  <= num2_d;
      disp_q  <= disp_d;
      dovf_q  <= dovf_d;
    end
  end

  assign num1       = num1_q;
  assign num2       = num2_q;
  assign disp_value = disp_q;
  assign disp_ovf   = dovf_q;
  assign state_led  = state_q;
endmodule

// File: tb/tb_operand_sequencer.sv
// Scoreboard bench for operand_sequencer with stub cores and a behavioural
// entry-flow model; a monitor checks every change of state/num1/num2.

module tb_operand_sequencer;
  localparam int DEB = 4;

  logic        clk = 1'b0, rst = 1'b0;
  logic [15:0] sw = '0;
  logic        btn_enter = 1'b0, btn_clear = 1'b0;
  logic [1:0]  op_sel = '0;
  logic [3:0]  ovf_in = '0;
  logic [15:0] fixA, fixM, floA, floM, num1, num2, disp_value;
  logic        disp_ovf;
  logic [1:0]  state_led;

  assign fixA = num1 + num2;
  assign fixM = 16'(32'(num1) * 32'(num2));
  assign floA = 16'hF00A;
  assign floM = 16'hF00D;

  operand_sequencer #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_enter(btn_enter), .btn_clear(btn_clear),
    .op_sel(op_sel), .fixA(fixA), .fixM(fixM), .floA(floA), .floM(floM), .ovf_in(ovf_in),
    .num1(num1), .num2(num2), .disp_value(disp_value), .disp_ovf(disp_ovf), .state_led(state_led)
  );

  always #5 clk = ~clk;

  typedef struct {logic [1:0] st; logic [15:0] n1; logic [15:0] n2;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  int m_state = 0;
  logic [15:0] m_num1 = '0, m_num2 = '0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_result(input logic [1:0] sel, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] s;
    case (sel)
      2'd0:    s = 32'(a) + 32'(b);
      2'd1:    s = 32'(a) * 32'(b);
      2'd2:    s = 32'hF00A;
      default: s = 32'hF00D;
    endcase
    return s[15:0];
  endfunction

  function automatic logic ref_ovf(input logic [1:0] sel, input logic [3:0] o);
    case (sel)
      2'd0:    return o[0];
      2'd1:    return o[1];
      2'd2:    return o[3];
      default: return o[2];
    endcase
  endfunction

  task automatic push(input int st, input logic [15:0] n1, input logic [15:0] n2);
    exp_t e;
    e.st = 2'(st); e.n1 = n1; e.n2 = n2;
    q.push_back(e);
  endtask

  task automatic model_enter();
    logic [15:0] r;
    case (m_state)
      0: begin push(1, sw, m_num2); m_num1 = sw; m_state = 1; end
      1: begin push(2, m_num1, sw); push(3, m_num1, sw); m_num2 = sw; m_state = 3; end
      default: begin
        r = ref_result(op_sel, m_num1, m_num2);
        push(1, r, m_num2); m_num1 = r; m_state = 1;
      end
    endcase
  endtask

  task automatic model_clear();
    if (m_state != 0 || m_num1 != 0 || m_num2 != 0) push(0, 16'h0, 16'h0);
    m_state = 0; m_num1 = '0; m_num2 = '0;
  endtask

  task automatic hold_btns(input bit e, input bit c);
    @(negedge clk);
    btn_enter = e; btn_clear = c;
    repeat (DEB + 6) @(negedge clk);
    btn_enter = 1'b0; btn_clear = 1'b0;
    repeat (DEB + 6) @(negedge clk);
  endtask

  task automatic check_disp(input string name);
    if (m_state == 3) begin
      check({name, "_disp"}, disp_value, ref_result(op_sel, m_num1, m_num2));
      check({name, "_ovf"}, 16'(disp_ovf), 16'(ref_ovf(op_sel, ovf_in)));
    end else begin
      check({name, "_disp"}, disp_value, sw);
      check({name, "_ovf"}, 16'(disp_ovf), 16'h0);
    end
    check({name, "_state"}, 16'(state_led), 16'(m_state));
  endtask

  // Monitor: any change of state/num1/num2 must match the next queued event.
  initial begin
    logic [33:0] prev;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      if ({state_led, num1, num2} !== prev) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event actual=%0h/%0h/%0h expected=none", state_led, num1, num2);
        end else begin
          e = q.pop_front();
          check("ev_state", 16'(state_led), 16'(e.st));
          check("ev_num1", num1, e.n1);
          check("ev_num2", num2, e.n2);
        end
        prev = {state_led, num1, num2};
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", 16'(state_led), 16'h0);
    check("rst_num1", num1, 16'h0);
    check("rst_num2", num2, 16'h0);
    check("rst_disp", disp_value, 16'h0);
    check("rst_ovf", 16'(disp_ovf), 16'h0);
    rst = 1'b0;

    // Reset in GET_B with a press in flight.
    sw = 16'd561; model_enter(); hold_btns(1, 0);
    check("a561_num1", num1, 16'd561);
    sw = 16'h1234;
    @(negedge clk) btn_enter = 1'b1;
    repeat (4) @(negedge clk);
    model_clear();
    #2 rst = 1'b1;
    #1;
    check("midrst_num1", num1, 16'h0);
    check("midrst_state", 16'(state_led), 16'h0);
    check("midrst_disp", disp_value, 16'h0);
    @(negedge clk) btn_enter = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_state", 16'(state_led), 16'h0);

    // Entry flow 27 + 42.
    op_sel = 2'b00;
    sw = 16'd27; model_enter(); hold_btns(1, 0);
    check_disp("getb");
    sw = 16'd42; model_enter(); hold_btns(1, 0);
    check("flow_disp69", disp_value, 16'd69);
    check_disp("flow");

    // Chaining 69 + 3.
    model_enter(); hold_btns(1, 0);
    check("chain_num1", num1, 16'd69);
    sw = 16'd3; model_enter(); hold_btns(1, 0);
    check("chain_disp72", disp_value, 16'd72);
    check_disp("chain");

    // Live op_sel change, one-cycle update.
    model_clear(); hold_btns(0, 1);
    sw = 16'hAA8E; model_enter(); hold_btns(1, 0);
    sw = 16'h5726; model_enter(); hold_btns(1, 0);
    check_disp("live_add");
    @(negedge clk); op_sel = 2'b01; ovf_in = 4'b0010;
    @(negedge clk);
    check("live_mul", disp_value, ref_result(2'b01, 16'hAA8E, 16'h5726));
    check("live_ovf", 16'(disp_ovf), 16'h1);
    op_sel = 2'b00; ovf_in = 4'b0000;

    // Clear wins over a simultaneous enter in GET_B.
    model_clear(); hold_btns(0, 1);
    sw = 16'h0BAD; model_enter(); hold_btns(1, 0);
    sw = 16'h0;
    model_clear(); hold_btns(1, 1);
    check("clrpri_state", 16'(state_led), 16'h0);
    check("clrpri_num1", num1, 16'h0);
    check("clrpri_num2", num2, 16'h0);
    check("clrpri_disp", disp_value, 16'h0);

    // Bouncy enter: toggle every 2 cycles, then hold -> one pulse only.
    sw = 16'h00C3; model_enter();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) btn_enter = (i % 2 == 0);
      @(negedge clk);
    end
    @(negedge clk) btn_enter = 1'b1;
    repeat (10) @(negedge clk);
    btn_enter = 1'b0;
    repeat (10) @(negedge clk);
    check("bounce_state", 16'(state_led), 16'h1);
    check("bounce_num1", num1, 16'h00C3);

    // Randomized entry/chain/clear sequence.
    for (int i = 0; i < 12; i++) begin
      sw = 16'($urandom); op_sel = 2'($urandom); ovf_in = 4'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        model_clear(); hold_btns(0, 1);
      end else begin
        model_enter(); hold_btns(1, 0);
      end
      check_disp("rand");
    end

    repeat (5) @(negedge clk);
    check("queue_empty", 16'(q.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
